// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
//   master : launches an operation (start, signed_op, A, B) and consumes the
//            result (busy, done, Q, R, div_by_zero, ovf)
//   slave  : the divider itself
interface seq_divider_if #(
  parameter int N = 8
);
  logic         start;
  logic         signed_op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;
  logic         ovf;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, Q, R, div_by_zero, ovf
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, Q, R, div_by_zero, ovf
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with a start/busy/done handshake.
// Unsigned or two's-complement operands, divide-by-zero and signed-overflow
// flags, N+2 busy cycles per division (2 for a zero divisor).
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : seq_divider_if.slave
//          in : start, signed_op, A, B (sampled when start is accepted in IDLE)
//          out: busy, done (one-cycle pulse), Q, R, div_by_zero, ovf
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// LOAD  | operand magnitudes and result signs formed
// CALC  | one restoring step per cycle, N steps, quotient MSB first
// FIX   | sign correction, results and flags registered, done raised
// DONE  | done high for this single cycle, then back to IDLE
module seq_divider #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          sgn_q;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  rem;
  logic [N-1:0]  dvd;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;

  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  r_r;
  logic          dz_r;
  logic          ovf_r;

  logic [N-1:0]  a_abs;
  logic [N-1:0]  b_abs;
  logic [N:0]    rem_sh;
  logic [N:0]    trial;
  logic          keep;
  logic          b_zero;
  logic          is_ovf;

  // Magnitudes are held as unsigned N-bit values, so |2^(N-1)| is exact.
  always_comb begin
    a_abs  = (sgn_q && a_q[N-1]) ? (~a_q + 1'b1) : a_q;
    b_abs  = (sgn_q && b_q[N-1]) ? (~b_q + 1'b1) : b_q;
    rem_sh = {rem, dvd[N-1]};
    trial  = rem_sh - {1'b0, b_mag};
    // rem_sh < 2*|B|, so bit N of the difference is set exactly when it went negative.
    keep   = ~trial[N];
    b_zero = (b_q == '0);
    is_ovf = sgn_q && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      b_mag  <= '0;
      rem    <= '0;
      dvd    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            sgn_q  <= bus.signed_op;
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          neg_q <= sgn_q & (a_q[N-1] ^ b_q[N-1]);
          neg_r <= sgn_q & a_q[N-1];
          b_mag <= b_abs;
          dvd   <= a_abs;
          rem   <= '0;
          cnt   <= CW'(N);
          // A zero divisor skips the iterations; FIX then publishes the fixed
          // result so done lands two cycles after acceptance.
          state <= b_zero ? FIX : CALC;
        end
        CALC: begin
          rem <= keep ? trial[N-1:0] : rem_sh[N-1:0];
          dvd <= {dvd[N-2:0], keep};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (b_zero) begin
            q_r   <= '1;
            r_r   <= a_q;
            dz_r  <= 1'b1;
            ovf_r <= 1'b0;
          end else begin
            q_r   <= neg_q ? (~dvd + 1'b1) : dvd;
            r_r   <= neg_r ? (~rem + 1'b1) : rem;
            dz_r  <= 1'b0;
            ovf_r <= is_ovf;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.div_by_zero = dz_r;
  assign bus.ovf         = ovf_r;
endmodule
